// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for the two-requester ALU front end: control fields,
// output-stage state and the requester index type.
package alu_arbiter_pkg;
  localparam int NUM_REQ = 2;

  typedef logic req_idx_t;

  typedef enum logic {ARB_EMPTY = 1'b0, ARB_FULL = 1'b1} arb_state_e;

  // Operation class lives in ALU_Control[4:3], funct3 in [2:0]
  typedef enum logic [1:0] {
    CLS_LOGIC  = 2'b00,
    CLS_ARITH  = 2'b01,
    CLS_BRANCH = 2'b10,
    CLS_PASS   = 2'b11
  } alu_class_e;

  localparam logic [2:0] F3_ADD  = 3'b000, F3_SLL  = 3'b001, F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011, F3_XOR  = 3'b100, F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110, F3_AND  = 3'b111;
  localparam logic [2:0] F3_SUB  = 3'b000, F3_SRA  = 3'b101;
  localparam logic [2:0] F3_BEQ  = 3'b000, F3_BNE  = 3'b001, F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters (master) and the arbiter (slave).
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][5:0]  req_control;
  logic [NUM_REQ-1:0][31:0] req_a;
  logic [NUM_REQ-1:0][31:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [31:0]              rsp_result;
  logic                     rsp_branch;

  modport master (output req_valid, req_control, req_a, req_b, rsp_ready,
                  input  req_ready, rsp_valid, rsp_result, rsp_branch);
  modport slave  (input  req_valid, req_control, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_result, rsp_branch);
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: logic/add, sub/arith shift, branch compare and pass-A classes.
module ALU
  import alu_arbiter_pkg::*;
(
  input  logic [5:0]  i_control,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_branch_op,
  output logic [31:0] o_result,
  output logic        o_branch
);
  logic       w_cond;
  logic       w_unused_ctl;
  logic [2:0] w_f3;

  assign w_f3         = i_control[2:0];
  assign w_unused_ctl = i_control[5];

  always_comb begin
    o_result = '0;
    w_cond   = 1'b0;
    case (i_control[4:3])
      CLS_LOGIC: begin
        case (w_f3)
          F3_ADD:  o_result = i_a + i_b;
          F3_SLL:  o_result = i_a << i_b[4:0];
          F3_SLT:  o_result = {31'b0, $signed(i_a) < $signed(i_b)};
          F3_SLTU: o_result = {31'b0, i_a < i_b};
          F3_XOR:  o_result = i_a ^ i_b;
          F3_SRL:  o_result = i_a >> i_b[4:0];
          F3_OR:   o_result = i_a | i_b;
          default: o_result = i_a & i_b;
        endcase
      end
      CLS_ARITH: begin
        if (w_f3 == F3_SRA) o_result = $signed(i_a) >>> i_b[4:0];
        else                o_result = i_a - i_b;
      end
      // Branch class reports only the decision; result stays zero
      CLS_BRANCH: begin
        case (w_f3)
          F3_BEQ:  w_cond = (i_a == i_b);
          F3_BNE:  w_cond = (i_a != i_b);
          F3_BLT:  w_cond = ($signed(i_a) < $signed(i_b));
          F3_BGE:  w_cond = ($signed(i_a) >= $signed(i_b));
          F3_BLTU: w_cond = (i_a < i_b);
          F3_BGEU: w_cond = (i_a >= i_b);
          default: w_cond = 1'b0;
        endcase
      end
      default: o_result = i_a;
    endcase
    o_branch = i_branch_op & w_cond;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one ALU between two requesters, with a
// one-entry output register returned to the issuing requester.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  alu_arbiter_if.slave bus
);
  arb_state_e  r_state;
  req_idx_t    r_owner;
  req_idx_t    r_prio;
  logic [31:0] r_result;
  logic        r_branch;

  req_idx_t    w_gnt;
  logic        w_gnt_vld;
  logic        w_can_accept;
  logic        w_accept;
  logic [5:0]  w_ctl;
  logic [31:0] w_alu_result;
  logic        w_alu_branch;

  // A lone requester wins outright; the pointer only breaks ties
  always_comb begin
    w_gnt_vld = |bus.req_valid;
    if (&bus.req_valid) w_gnt = r_prio;
    else                w_gnt = bus.req_valid[1];
  end

  assign w_can_accept = (r_state == ARB_EMPTY) || bus.rsp_ready[r_owner];
  assign w_accept     = reset_n && w_gnt_vld && w_can_accept;
  assign w_ctl        = bus.req_control[w_gnt];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
    assign bus.req_ready[g] = w_accept && (w_gnt == req_idx_t'(g));
    assign bus.rsp_valid[g] = (r_state == ARB_FULL) && (r_owner == req_idx_t'(g));
  end

  assign bus.rsp_result = r_result;
  assign bus.rsp_branch = r_branch;

  ALU u_alu (
    .i_control   (w_ctl),
    .i_a         (bus.req_a[w_gnt]),
    .i_b         (bus.req_b[w_gnt]),
    .i_branch_op (w_ctl[4:3] == CLS_BRANCH),
    .o_result    (w_alu_result),
    .o_branch    (w_alu_branch)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ARB_EMPTY;
      r_owner  <= 1'b0;
      r_prio   <= 1'b0;
      r_result <= '0;
      r_branch <= 1'b0;
    end else if (w_accept) begin
      // Covers drain+accept too: the new owner may differ from the old one
      r_state  <= ARB_FULL;
      r_owner  <= w_gnt;
      r_prio   <= ~w_gnt;
      r_result <= w_alu_result;
      r_branch <= w_alu_branch;
    end else if (r_state == ARB_FULL && bus.rsp_ready[r_owner]) begin
      r_state  <= ARB_EMPTY;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single ops plus hand sequences for
// contention, backpressure, drain+accept and reset while full.
module tb_alu_arbiter;
  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        port;
    logic [5:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic port, input logic [5:0] ctl,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_control[port] = ctl;
    bus.req_a[port]       = a;
    bus.req_b[port]       = b;
  endtask

  function automatic logic [1:0] oh(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

  initial begin
    logic        exp_g, prev_g, have_prev;
    logic [31:0] prev_res;
    int          n0, n1;

    vecs[0]  = '{1'b0, 6'b000000, 32'd5,        32'd3,  32'd8,          1'b0};
    vecs[1]  = '{1'b1, 6'b001000, 32'd3,        32'd5,  32'hFFFFFFFE,   1'b0};
    vecs[2]  = '{1'b0, 6'b000111, 32'hF0,       32'h3C, 32'h30,         1'b0};
    vecs[3]  = '{1'b0, 6'b000110, 32'hF0,       32'h0F, 32'hFF,         1'b0};
    vecs[4]  = '{1'b1, 6'b000100, 32'hFF,       32'h0F, 32'hF0,         1'b0};
    vecs[5]  = '{1'b0, 6'b000001, 32'd1,        32'd4,  32'd16,         1'b0};
    vecs[6]  = '{1'b1, 6'b001101, 32'h80000000, 32'd4,  32'hF8000000,   1'b0};
    vecs[7]  = '{1'b0, 6'b000101, 32'h80000000, 32'd4,  32'h08000000,   1'b0};
    vecs[8]  = '{1'b0, 6'b000010, 32'hFFFFFFFF, 32'd1,  32'd1,          1'b0};
    vecs[9]  = '{1'b0, 6'b000011, 32'hFFFFFFFF, 32'd1,  32'd0,          1'b0};
    vecs[10] = '{1'b1, 6'b010000, 32'd7,        32'd7,  32'd0,          1'b1};
    vecs[11] = '{1'b1, 6'b010000, 32'd7,        32'd8,  32'd0,          1'b0};
    vecs[12] = '{1'b0, 6'b010001, 32'd7,        32'd8,  32'd0,          1'b1};
    vecs[13] = '{1'b1, 6'b010100, 32'hFFFFFFFF, 32'd0,  32'd0,          1'b1};
    vecs[14] = '{1'b1, 6'b010110, 32'hFFFFFFFF, 32'd0,  32'd0,          1'b0};
    vecs[15] = '{1'b0, 6'b011000, 32'd9,        32'd0,  32'd9,          1'b0};

    // Reset: ready must stay low even with both requesters valid
    reset_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    bus.req_control = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset req_ready", bus.req_ready, 2'b00);
    chk("reset rsp_valid", bus.rsp_valid, 2'b00);
    chk("reset rsp_result", bus.rsp_result, 32'd0);
    chk("reset rsp_branch", bus.rsp_branch, 1'b0);
    bus.req_valid = 2'b00;
    reset_n = 1'b1;

    // Single operations from the table
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      bus.req_valid = oh(vecs[i].port);
      bus.rsp_ready = 2'b11;
      set_req(vecs[i].port, vecs[i].ctl, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("vec%0d req_ready", i), bus.req_ready, oh(vecs[i].port));
      @(negedge clock);
      bus.req_valid = 2'b00;
      #1;
      chk($sformatf("vec%0d rsp_valid", i), bus.rsp_valid, oh(vecs[i].port));
      chk($sformatf("vec%0d rsp_result", i), bus.rsp_result, vecs[i].res);
      chk($sformatf("vec%0d rsp_branch", i), bus.rsp_branch, vecs[i].br);
    end

    // Backpressure: port 1 SUB held while its consumer stalls
    @(negedge clock);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b01;
    set_req(1'b1, 6'b001000, 32'd3, 32'd5);
    #1;
    chk("bp accept", bus.req_ready, 2'b10);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      bus.req_valid = 2'b01;
      set_req(1'b0, 6'b000000, 32'd1, 32'd1);
      #1;
      chk($sformatf("bp%0d req_ready", c), bus.req_ready, 2'b00);
      chk($sformatf("bp%0d rsp_valid", c), bus.rsp_valid, 2'b10);
      chk($sformatf("bp%0d rsp_result", c), bus.rsp_result, 32'hFFFFFFFE);
    end
    // Release: port 1 drains while port 0 is accepted in the same cycle
    @(negedge clock);
    bus.rsp_ready = 2'b11;
    #1;
    chk("bp release req_ready", bus.req_ready, 2'b01);
    chk("bp release rsp_valid", bus.rsp_valid, 2'b10);
    @(negedge clock);
    bus.req_valid = 2'b00;
    #1;
    chk("bp next rsp_valid", bus.rsp_valid, 2'b01);
    chk("bp next rsp_result", bus.rsp_result, 32'd2);

    // Drain+accept: owner 0 full, port 1 pass-A accepted on drain
    @(negedge clock);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    set_req(1'b0, 6'b000000, 32'd2, 32'd2);
    #1;
    chk("da first accept", bus.req_ready, 2'b01);
    @(negedge clock);
    bus.req_valid = 2'b10;
    set_req(1'b1, 6'b011000, 32'd9, 32'd0);
    #1;
    chk("da stalled", bus.req_ready, 2'b00);
    bus.rsp_ready = 2'b01;
    #1;
    chk("da req_ready", bus.req_ready, 2'b10);
    chk("da rsp_result old", bus.rsp_result, 32'd4);
    @(negedge clock);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    #1;
    chk("da rsp_valid", bus.rsp_valid, 2'b10);
    chk("da rsp_result", bus.rsp_result, 32'd9);

    // Reset while full discards the held result
    @(negedge clock);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    set_req(1'b0, 6'b000000, 32'd5, 32'd3);
    @(negedge clock);
    bus.req_valid = 2'b11;
    #1;
    chk("rst full rsp_valid", bus.rsp_valid, 2'b01);
    reset_n = 1'b0;
    #1;
    chk("rst req_ready forced", bus.req_ready, 2'b00);
    @(negedge clock);
    #1;
    chk("rst rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst rsp_result", bus.rsp_result, 32'd0);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    reset_n = 1'b1;

    // Contention: 4 ops per port, grants alternate starting with port 0
    exp_g = 1'b0;
    prev_g = 1'b0;
    prev_res = '0;
    have_prev = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      if (have_prev) begin
        #1;
        chk($sformatf("cont%0d rsp_valid", c), bus.rsp_valid, oh(prev_g));
        chk($sformatf("cont%0d rsp_result", c), bus.rsp_result, prev_res);
      end
      have_prev = 1'b0;
      bus.req_valid = {n1 < 4, n0 < 4};
      set_req(1'b0, 6'b000000, 32'(n0), 32'd100);
      set_req(1'b1, 6'b011000, 32'(200 + n1), 32'd0);
      #1;
      if (n0 < 4 || n1 < 4) begin
        chk($sformatf("cont%0d req_ready", c), bus.req_ready, oh(exp_g));
        prev_g = exp_g;
        have_prev = 1'b1;
        if (exp_g) begin
          prev_res = 32'(200 + n1);
          n1++;
        end else begin
          prev_res = 32'(100 + n0);
          n0++;
        end
        exp_g = ~exp_g;
      end
    end
    bus.req_valid = 2'b00;
    @(negedge clock);
    #1;
    chk("final idle rsp_valid", bus.rsp_valid, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end that shares the single combinational `ALU` between the main execute path (port 0) and an auxiliary requester such as an address or branch-resolve unit (port 1). It arbitrates round-robin, captures `ALU_result` and `branch` in a one-entry output register, and returns each result to the requester that issued it over a valid/ready handshake. Throughput is one operation per cycle while the owning requester drains its response.

## Interface
- `NUM_REQ`, 2, number of requesters; fixed at 2 and not otherwise supported.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid[i]`  in  1  requester i presents an operation.
- `req_ready[i]`  out  1  operation from requester i is accepted this cycle.
- `req_control[i]`  in  6  `ALU_Control` encoding for requester i.
- `req_a[i]`, `req_b[i]`  in  32 each  operands for requester i.
- `rsp_valid[i]`  out  1  the held result belongs to requester i.
- `rsp_ready[i]`  in  1  requester i consumes its response.
- `rsp_result`  out  32  held ALU result, shared by both requesters and qualified by `rsp_valid[i]`.
- `rsp_branch`  out  1  held branch decision, qualified the same way.

## Operation
- Output stage FSM with two states.
  - EMPTY: no result held.
  - FULL: result held; `owner` names the requester it belongs to.
- `can_accept` = EMPTY, or (FULL and `rsp_ready[owner]`).
- Grant is combinational:
  - Only one `req_valid` high: grant that requester.
  - Both high: grant the requester named by priority pointer `prio`.
  - `req_ready[i]` = grant_i and `can_accept`.
- The ALU is driven by the operands and control of the granted requester. When nothing is granted, it is driven with requester 0's fields; its output is then ignored.
- On accept:
  - Register `ALU_result` and `branch`.
  - Set `owner` to the granted requester.
  - Go to FULL.
  - Set `prio` to the other requester.
- On drain without a new accept: go to EMPTY.
- Drain and accept in the same cycle: stay FULL and load the new result, which may have a different owner.
- Requester rules: while `req_valid[i]` is high and `req_ready[i]` is low, the requester holds its payload stable. The arbiter does not sample the payload in those cycles.
- `rsp_valid[i]` = FULL and (`owner` == i). `rsp_result` and `rsp_branch` stay stable until consumed.
- Result width is 32 bits with no extension; the arbiter passes the ALU output through unmodified.

## Timing
- Reset (`reset_n` low at an edge):
  - State goes to EMPTY, `prio` = 0, `owner` = 0.
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_branch` = 0.
  - `req_ready` is forced to 0 while `reset_n` is low.
- Reset while FULL discards the held result; no response is delivered.
- Latency: an operation accepted at edge N has `rsp_valid` high after edge N, in cycle N+1.
- Back-to-back: with the owner holding `rsp_ready` high, a new accept occurs every cycle.
- Backpressure: while FULL and the owner holds `rsp_ready` low, `req_ready` = 0 on both ports. A requester whose `rsp_valid` is low cannot release the stage, even with `rsp_ready` high.
- Fairness: under continuous contention, grants alternate 0,1,0,1 and neither port waits more than one accept.

## Structure
- Shared package holds:
  - `ALU_Control` field constants: class in [4:3] (00 logic/add, 01 sub/arith shift, 10 branch, 11 pass A) and the funct3 codes.
  - State encoding `ARB_EMPTY` / `ARB_FULL`.
  - Requester index type.
- Sub-module: one instance of the existing `ALU`. Its `branch_op` input is tied to 1 when control[4:3] == 2'b10.
- Grant logic, FSM and output register live in `alu_arbiter`.

## Test plan
- Single op: port 0 sends control 6'b000000 with A=5, B=3 while `rsp_ready[0]`=1 -> `req_ready[0]`=1, and next cycle `rsp_valid[0]`=1 with `rsp_result`=8.
- Contention: both ports valid every cycle, 4 ops each, both `rsp_ready`=1 -> grants alternate 0,1,0,… with one result per cycle, each returned to the correct port.
- Backpressure: port 1 sends SUB (6'b001000) with A=3, B=5 and holds `rsp_ready[1]`=0 for 3 cycles -> `rsp_result`=32'hFFFFFFFE held stable, and both `req_ready`=0 until release.
- Branch: port 1 sends BEQ (6'b010000) with A=B=7 -> `rsp_branch`=1, `rsp_result`=0. Then A=7, B=8 -> `rsp_branch`=0.
- Drain+accept: while FULL (owner 0), assert `rsp_ready[0]` with port 1 valid (6'b011000, A=9) -> same cycle accept, and next cycle `rsp_valid[1]`=1 with `rsp_result`=9.
- Reset mid-op: assert `reset_n`=0 while FULL -> next cycle all `rsp_valid`=0 and `rsp_result`=0. After release, contention grants port 0 first.
